// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: condition codes, ROB age helper,
// the per-lane evaluate-stage record and the redirect FSM state encoding.
package branch_resolve_unit_pkg;

   localparam int BRU_XLEN  = 32;
   localparam int BRU_LANES = 2;
   localparam int BRU_TAG_W = 6;

   // op[2:0] condition field; op[3] selects unsigned compare for lt/gt/le/ge
   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_EQ   = 3'b001;
   localparam logic [2:0] BR_NE   = 3'b010;
   localparam logic [2:0] BR_LT   = 3'b011;
   localparam logic [2:0] BR_GT   = 3'b100;
   localparam logic [2:0] BR_LE   = 3'b101;
   localparam logic [2:0] BR_GE   = 3'b110;
   localparam logic [2:0] BR_JMP  = 3'b111;

   typedef enum logic [0:0] {
      RS_IDLE = 1'b0,
      RS_HOLD = 1'b1
   } redir_state_e;

   typedef struct packed {
      logic                valid;
      logic                taken;
      logic                mispred;
      logic [BRU_XLEN-1:0] pc;
      logic [BRU_TAG_W-1:0] tag;
   } s1_rec_t;

   // Distance from the ROB head; the truncating subtraction is the modulo.
   function automatic logic [BRU_TAG_W-1:0] bru_age(input logic [BRU_TAG_W-1:0] tag,
                                                    input logic [BRU_TAG_W-1:0] head);
      return tag - head;
   endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Issue, resolve and redirect signals of the branch resolve unit.
// master = core/front-end side that issues and consumes; slave = the unit.
interface branch_resolve_if import branch_resolve_unit_pkg::*; #(
   parameter int LANES = BRU_LANES
) ();

   // Handshakes: lane i transfers on a rising edge where in_valid[i] && in_ready;
   // the redirect transfers on a rising edge where redir_valid && redir_ready.
   // A valid, once raised, keeps its payload stable until it transfers.
   logic [LANES-1:0]                in_valid;
   logic                            in_ready;
   logic [LANES-1:0][3:0]           in_op;
   logic [LANES-1:0][BRU_XLEN-1:0]  in_op1;
   logic [LANES-1:0][BRU_XLEN-1:0]  in_op2;
   logic [LANES-1:0]                in_pred_taken;
   logic [LANES-1:0][BRU_XLEN-1:0]  in_target;
   logic [LANES-1:0][BRU_XLEN-1:0]  in_fallthru;
   logic [LANES-1:0][BRU_TAG_W-1:0] in_tag;
   logic [BRU_TAG_W-1:0]            rob_head;
   logic                            flush;

   logic [LANES-1:0]                res_valid;
   logic [LANES-1:0]                res_taken;
   logic [LANES-1:0]                res_mispred;
   logic [LANES-1:0][BRU_TAG_W-1:0] res_tag;

   logic                            redir_valid;
   logic                            redir_ready;
   logic [BRU_XLEN-1:0]             redir_pc;
   logic [BRU_TAG_W-1:0]            redir_tag;

   modport master (
      output in_valid, in_op, in_op1, in_op2, in_pred_taken, in_target, in_fallthru,
             in_tag, rob_head, flush, redir_ready,
      input  in_ready, res_valid, res_taken, res_mispred, res_tag,
             redir_valid, redir_pc, redir_tag
   );

   modport slave (
      input  in_valid, in_op, in_op1, in_op2, in_pred_taken, in_target, in_fallthru,
             in_tag, rob_head, flush, redir_ready,
      output in_ready, res_valid, res_taken, res_mispred, res_tag,
             redir_valid, redir_pc, redir_tag
   );

endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition evaluator: maps op and two operands to taken.
module branch_cond_eval import branch_resolve_unit_pkg::*; #(
   parameter int XLEN = BRU_XLEN
) (
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            taken
);

   logic is_eq;
   logic is_lt;

   assign is_eq = (op1 == op2);
   // One less-than serves all ordered conditions; op[3] picks the signedness.
   assign is_lt = op[3] ? (op1 < op2) : ($signed(op1) < $signed(op2));

   always_comb begin
      taken = 1'b0;
      case (op[2:0])
         BR_EQ:   taken = is_eq;
         BR_NE:   taken = !is_eq;
         BR_LT:   taken = is_lt;
         BR_GT:   taken = !is_lt && !is_eq;
         BR_LE:   taken = is_lt || is_eq;
         BR_GE:   taken = !is_lt;
         BR_JMP:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Multi-lane branch resolve unit: evaluate stage registers, oldest-mispredict
// selector, and a held front-end redirect FSM.
module branch_resolve_unit import branch_resolve_unit_pkg::*; #(
   parameter int LANES = BRU_LANES
) (
   input  logic           clk,
   input  logic           rst_n,
   branch_resolve_if.slave bus,
   output redir_state_e   dbg_state
);

   localparam int XLEN  = BRU_XLEN;
   localparam int TAG_W = BRU_TAG_W;

   logic [LANES-1:0] eval_taken;
   s1_rec_t          s1_q [LANES];
   s1_rec_t          s1_d [LANES];

   logic             sel_valid;
   logic [TAG_W-1:0] sel_age;
   logic [XLEN-1:0]  sel_pc;
   logic [TAG_W-1:0] sel_tag;

   redir_state_e     state_q, state_d;
   logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
   logic [TAG_W-1:0] redir_tag_q, redir_tag_d;
   logic             held_is_younger;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      branch_cond_eval #(.XLEN(XLEN)) u_eval (
         .op    (bus.in_op[i]),
         .op1   (bus.in_op1[i]),
         .op2   (bus.in_op2[i]),
         .taken (eval_taken[i])
      );
   end

   assign bus.in_ready = (state_q != RS_HOLD);

   // Oldest mispredict among the lanes being resolved; strict compare keeps
   // the lowest lane on equal age.
   always_comb begin
      sel_valid = 1'b0;
      sel_age   = '1;
      sel_pc    = '0;
      sel_tag   = '0;
      for (int i = 0; i < LANES; i++) begin
         if (s1_q[i].valid && s1_q[i].mispred &&
             (!sel_valid || (bru_age(s1_q[i].tag, bus.rob_head) < sel_age))) begin
            sel_valid = 1'b1;
            sel_age   = bru_age(s1_q[i].tag, bus.rob_head);
            sel_pc    = s1_q[i].pc;
            sel_tag   = s1_q[i].tag;
         end
      end
   end

   always_comb begin
      bus.res_valid   = '0;
      bus.res_taken   = '0;
      bus.res_mispred = '0;
      bus.res_tag     = '0;
      for (int i = 0; i < LANES; i++) begin
         bus.res_valid[i]   = s1_q[i].valid;
         bus.res_taken[i]   = s1_q[i].valid && s1_q[i].taken;
         bus.res_mispred[i] = s1_q[i].valid && s1_q[i].mispred;
         bus.res_tag[i]     = s1_q[i].valid ? s1_q[i].tag : '0;
      end
   end

   // Every entry is reported exactly once, so valid drops after its cycle on
   // the resolve bus; the payload is only replaced by a new accepted issue.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         s1_d[i]       = s1_q[i];
         s1_d[i].valid = 1'b0;
         if (bus.in_ready && bus.in_valid[i]) begin
            s1_d[i].valid   = 1'b1;
            s1_d[i].taken   = eval_taken[i];
            s1_d[i].mispred = (bus.in_op[i][2:0] != BR_NONE) &&
                              (eval_taken[i] != bus.in_pred_taken[i]);
            s1_d[i].pc      = eval_taken[i] ? bus.in_target[i] : bus.in_fallthru[i];
            s1_d[i].tag     = bus.in_tag[i];
            // Branches younger than the one being redirected are wrong-path.
            if (sel_valid && (bru_age(bus.in_tag[i], bus.rob_head) > sel_age)) begin
               s1_d[i].valid = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
         for (int i = 0; i < LANES; i++) begin
            s1_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            s1_q[i] <= s1_d[i];
         end
      end
   end

   assign held_is_younger = sel_age < bru_age(redir_tag_q, bus.rob_head);

   always_comb begin
      state_d     = state_q;
      redir_pc_d  = redir_pc_q;
      redir_tag_d = redir_tag_q;
      case (state_q)
         RS_IDLE: begin
            if (sel_valid) begin
               state_d     = RS_HOLD;
               redir_pc_d  = sel_pc;
               redir_tag_d = sel_tag;
            end
         end
         RS_HOLD: begin
            // An older mispredict supersedes the held one even if the front
            // end accepts this cycle, since the held target is then stale.
            if (sel_valid && held_is_younger) begin
               redir_pc_d  = sel_pc;
               redir_tag_d = sel_tag;
            end else if (bus.redir_ready) begin
               state_d = RS_IDLE;
            end
         end
         default: state_d = RS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
         state_q     <= RS_IDLE;
         redir_pc_q  <= '0;
         redir_tag_q <= '0;
      end else begin
         state_q     <= state_d;
         redir_pc_q  <= redir_pc_d;
         redir_tag_q <= redir_tag_d;
      end
   end

   assign bus.redir_valid = (state_q == RS_HOLD);
   assign bus.redir_pc    = redir_pc_q;
   assign bus.redir_tag   = redir_tag_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a cycle-level reference model.
module tb_branch_resolve_unit;
   import branch_resolve_unit_pkg::*;

   localparam int LANES = 2;
   localparam int XLEN  = BRU_XLEN;
   localparam int TAG_W = BRU_TAG_W;

   logic clk = 1'b0;
   logic rst_n;
   redir_state_e dbg_state;
   int checks = 0;
   int errors = 0;

   branch_resolve_if #(.LANES(LANES)) bus ();

   branch_resolve_unit #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int age_of(input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] head);
      return ((int'(tag) - int'(head)) % 64 + 64) % 64;
   endfunction

   function automatic bit cond_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'(a);
      sb = longint'(b);
      if (!op[3]) begin
         if (a[31]) sa = sa - 64'sd4294967296;
         if (b[31]) sb = sb - 64'sd4294967296;
      end
      case (op[2:0])
         3'd1: return sa == sb;
         3'd2: return sa != sb;
         3'd3: return sa < sb;
         3'd4: return sa > sb;
         3'd5: return sa <= sb;
         3'd6: return sa >= sb;
         3'd7: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   bit              model_live = 0;
   bit              p_valid   [LANES];
   bit              p_taken   [LANES];
   bit              p_mispred [LANES];
   logic [XLEN-1:0] p_pc      [LANES];
   logic [TAG_W-1:0] p_tag    [LANES];
   bit              m_hold, m_zero;
   logic [XLEN-1:0] m_rpc;
   logic [TAG_W-1:0] m_rtag;
   logic [XLEN+TAG_W-1:0] exp_q[$];
   logic [XLEN+TAG_W-1:0] got_q[$];

   always @(posedge clk) begin
      int best_age;
      int best_i;
      bit found;
      bit accept;
      bit t;
      if (!rst_n || bus.flush) begin
         for (int i = 0; i < LANES; i++) p_valid[i] = 0;
         m_hold = 0; m_zero = 1; m_rpc = '0; m_rtag = '0;
      end else begin
         found = 0; best_age = 64; best_i = 0;
         for (int i = 0; i < LANES; i++)
            if (p_valid[i] && p_mispred[i] && age_of(p_tag[i], bus.rob_head) < best_age) begin
               found = 1; best_age = age_of(p_tag[i], bus.rob_head); best_i = i;
            end
         accept = !m_hold;
         if (found && (!m_hold || best_age < age_of(m_rtag, bus.rob_head))) begin
            m_hold = 1; m_zero = 0; m_rpc = p_pc[best_i]; m_rtag = p_tag[best_i];
         end else if (m_hold && bus.redir_ready) begin
            exp_q.push_back({m_rpc, m_rtag});
            m_hold = 0;
         end
         for (int i = 0; i < LANES; i++) begin
            p_valid[i] = 0;
            if (accept && bus.in_valid[i] &&
                !(found && age_of(bus.in_tag[i], bus.rob_head) > best_age)) begin
               t = cond_taken(bus.in_op[i], bus.in_op1[i], bus.in_op2[i]);
               p_valid[i]   = 1;
               p_taken[i]   = t;
               p_mispred[i] = (bus.in_op[i][2:0] != 3'd0) && (t != bus.in_pred_taken[i]);
               p_pc[i]      = t ? bus.in_target[i] : bus.in_fallthru[i];
               p_tag[i]     = bus.in_tag[i];
            end
         end
      end
      model_live = 1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_live) begin
         for (int i = 0; i < LANES; i++) begin
            check($sformatf("res_valid[%0d]", i), bus.res_valid[i], p_valid[i]);
            check($sformatf("res_taken[%0d]", i), bus.res_taken[i], p_valid[i] && p_taken[i]);
            check($sformatf("res_mispred[%0d]", i), bus.res_mispred[i], p_valid[i] && p_mispred[i]);
            check($sformatf("res_tag[%0d]", i), bus.res_tag[i], p_valid[i] ? p_tag[i] : 6'd0);
         end
         check("in_ready", bus.in_ready, !m_hold);
         check("redir_valid", bus.redir_valid, m_hold);
         check("fsm_state", dbg_state, m_hold ? RS_HOLD : RS_IDLE);
         if (m_hold || m_zero) begin
            check("redir_pc", bus.redir_pc, m_rpc);
            check("redir_tag", bus.redir_tag, m_rtag);
         end
         if (rst_n && !bus.flush && bus.redir_valid && bus.redir_ready)
            got_q.push_back({bus.redir_pc, bus.redir_tag});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
      bus.in_valid = '0;
      bus.flush    = 1'b0;
   endtask

   task automatic issue(input int lane, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic pred, input logic [31:0] tgt,
                        input logic [5:0] tag);
      bus.in_valid[lane]      = 1'b1;
      bus.in_op[lane]         = op;
      bus.in_op1[lane]        = a;
      bus.in_op2[lane]        = b;
      bus.in_pred_taken[lane] = pred;
      bus.in_target[lane]     = tgt;
      bus.in_fallthru[lane]   = 32'h8000_0000 | (32'(tag) << 2);
      bus.in_tag[lane]        = tag;
   endtask

   task automatic handshake();
      bus.redir_ready = 1'b1;
      step();
      bus.redir_ready = 1'b0;
      check("hs_redir_valid_low", bus.redir_valid, 1'b0);
      check("hs_in_ready", bus.in_ready, 1'b1);
   endtask

   logic [3:0]  t_op   [10] = '{4'b0001, 4'b0010, 4'b0011, 4'b1011, 4'b0100,
                                 4'b1100, 4'b0101, 4'b1110, 4'b0000, 4'b1111};
   logic [31:0] t_a    [10] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1,
                                 32'd1, 32'd7, 32'd3, 32'd1, 32'd0};
   logic [31:0] t_b    [10] = '{32'd5, 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'd7, 32'd4, 32'd1, 32'd9};
   logic        t_exp  [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic        t_pred [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      rst_n = 1'b0;
      bus.in_valid = '0; bus.in_op = '0; bus.in_op1 = '0; bus.in_op2 = '0;
      bus.in_pred_taken = '0; bus.in_target = '0; bus.in_fallthru = '0; bus.in_tag = '0;
      bus.rob_head = '0; bus.flush = 1'b0; bus.redir_ready = 1'b0;
      step(); step();
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_redir_valid", bus.redir_valid, 1'b0);
      check("rst_res_valid", bus.res_valid, 2'b00);
      rst_n = 1'b1;

      // signed lt mispredict, then the unsigned variant
      issue(0, 4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_1000, 6'd1);
      step();
      check("t1_res_valid", bus.res_valid, 2'b01);
      check("t1_res_taken", bus.res_taken[0], 1'b1);
      check("t1_res_mispred", bus.res_mispred[0], 1'b1);
      step();
      check("t1_redir_valid", bus.redir_valid, 1'b1);
      check("t1_redir_pc", bus.redir_pc, 32'h0000_1000);
      check("t1_redir_tag", bus.redir_tag, 6'd1);
      handshake();
      issue(0, 4'b1011, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_1000, 6'd2);
      step();
      check("t1b_res_taken", bus.res_taken[0], 1'b0);
      check("t1b_res_mispred", bus.res_mispred[0], 1'b0);
      step();
      check("t1b_no_redirect", bus.redir_valid, 1'b0);

      // condition table, two lanes per cycle, predictions mostly correct
      for (int k = 0; k < 10; k += 2) begin
         issue(0, t_op[k], t_a[k], t_b[k], t_pred[k], 32'h100, 6'(k));
         issue(1, t_op[k+1], t_a[k+1], t_b[k+1], t_pred[k+1], 32'h200, 6'(k+1));
         step();
         check($sformatf("cond_taken_%0d", k), bus.res_taken, {t_exp[k+1], t_exp[k]});
         check($sformatf("cond_mispred_%0d", k), bus.res_mispred, 2'b00);
      end
      step();

      // two mispredicts in one cycle, age ordering with and without wrap
      bus.rob_head = 6'd2;
      issue(0, 4'b0111, 32'd0, 32'd0, 1'b0, 32'h500, 6'd5);
      issue(1, 4'b0111, 32'd0, 32'd0, 1'b0, 32'h300, 6'd3);
      step(); step();
      check("t2_redir_tag", bus.redir_tag, 6'd3);
      check("t2_redir_pc", bus.redir_pc, 32'h300);
      handshake();
      bus.rob_head = 6'd4;
      issue(0, 4'b0111, 32'd0, 32'd0, 1'b0, 32'h500, 6'd5);
      issue(1, 4'b0111, 32'd0, 32'd0, 1'b0, 32'h300, 6'd3);
      step(); step();
      check("t2w_redir_tag", bus.redir_tag, 6'd5);
      check("t2w_redir_pc", bus.redir_pc, 32'h500);
      handshake();
      bus.rob_head = 6'd0;

      // held redirect, stalled issue, older mispredict replacement
      issue(0, 4'b0111, 32'd0, 32'd0, 1'b0, 32'hA00, 6'd10);
      step();
      issue(0, 4'b0111, 32'd0, 32'd0, 1'b0, 32'h800, 6'd8);
      step();
      check("t3_hold_tag", bus.redir_tag, 6'd10);
      check("t3_in_ready", bus.in_ready, 1'b0);
      issue(1, 4'b0111, 32'd0, 32'd0, 1'b0, 32'h200, 6'd2);
      step();
      for (int c = 0; c < 3; c++) begin
         check($sformatf("t3_replaced_tag_%0d", c), bus.redir_tag, 6'd8);
         check($sformatf("t3_replaced_pc_%0d", c), bus.redir_pc, 32'h800);
         check($sformatf("t3_stall_%0d", c), bus.in_ready, 1'b0);
         check($sformatf("t3_no_res_%0d", c), bus.res_valid, 2'b00);
         if (c < 2) step();
      end
      handshake();

      // younger branch behind a selected mispredict is killed
      issue(0, 4'b0111, 32'd0, 32'd0, 1'b0, 32'h700, 6'd7);
      step();
      issue(0, 4'b0111, 32'd0, 32'd0, 1'b1, 32'h900, 6'd9);
      issue(1, 4'b0111, 32'd0, 32'd0, 1'b1, 32'h600, 6'd6);
      step();
      check("t4_res_valid", bus.res_valid, 2'b10);
      check("t4_res_tag1", bus.res_tag[1], 6'd6);
      check("t4_redir_tag", bus.redir_tag, 6'd7);
      handshake();

      // flush against a mispredict and a redirect handshake
      issue(0, 4'b0111, 32'd0, 32'd0, 1'b0, 32'h1400, 6'd20);
      step();
      issue(0, 4'b0111, 32'd0, 32'd0, 1'b0, 32'h0F00, 6'd15);
      step();
      bus.flush = 1'b1;
      bus.redir_ready = 1'b1;
      issue(1, 4'b0111, 32'd0, 32'd0, 1'b0, 32'h0100, 6'd1);
      step();
      bus.redir_ready = 1'b0;
      check("t5_res_valid", bus.res_valid, 2'b00);
      check("t5_res_mispred", bus.res_mispred, 2'b00);
      check("t5_redir_valid", bus.redir_valid, 1'b0);
      check("t5_redir_pc", bus.redir_pc, 32'h0);
      check("t5_redir_tag", bus.redir_tag, 6'd0);
      check("t5_state", dbg_state, RS_IDLE);
      check("t5_in_ready", bus.in_ready, 1'b1);

      // reset pulse while holding, then immediate issue
      issue(0, 4'b0111, 32'd0, 32'd0, 1'b0, 32'h0C00, 6'd3);
      step(); step();
      check("t6_holding", bus.redir_valid, 1'b1);
      rst_n = 1'b0;
      step();
      check("t6_rst_redir_valid", bus.redir_valid, 1'b0);
      check("t6_rst_redir_pc", bus.redir_pc, 32'h0);
      check("t6_rst_in_ready", bus.in_ready, 1'b1);
      rst_n = 1'b1;
      issue(0, 4'b0010, 32'd1, 32'd2, 1'b0, 32'h1100, 6'd1);
      step();
      check("t6_res_valid", bus.res_valid, 2'b01);
      check("t6_res_mispred", bus.res_mispred, 2'b01);
      step();
      check("t6_redir_pc", bus.redir_pc, 32'h1100);
      handshake();
      step(); step();

      check("redir_count_lit", got_q.size(), 6);
      check("redir_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("redir_seq_%0d", i), got_q[i], exp_q[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Multi-lane, pipelined branch resolution unit for the out-of-order superscalar core. Each lane evaluates a branch condition (signed or unsigned), compares the actual outcome against the front-end prediction, and reports the result to the ROB. The unit selects the oldest mispredicted branch across lanes and issues a single held front-end redirect. It replaces the single-lane combinational branch decision logic, adding lane count, operand width, signedness, prediction checking, age ordering and flush handling.

## Interface
- XLEN, 32, operand and PC width
- LANES, 2, branch lanes resolved per cycle (1..4)
- TAG_W, 6, ROB tag width; age is computed modulo 2^TAG_W

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  LANES  per-lane issue valid
- in_ready  out  1  common to all lanes; lanes accept when in_valid[i] && in_ready
- in_op  in  4*LANES  per lane: [2:0] condition, [3] unsigned
- in_op1, in_op2  in  XLEN*LANES  compare operands
- in_pred_taken  in  LANES  front-end prediction
- in_target, in_fallthru  in  XLEN*LANES  taken target and PC+4
- in_tag  in  TAG_W*LANES  ROB tag
- rob_head  in  TAG_W  tag of the oldest in-flight instruction
- flush  in  1  global squash
- res_valid  out  LANES  resolve bus to ROB, one cycle per branch
- res_taken, res_mispred  out  LANES  actual outcome and mismatch vs prediction
- res_tag  out  TAG_W*LANES
- redir_valid  out  1  front-end redirect request
- redir_ready  in  1  front end accepts the redirect
- redir_pc  out  XLEN  correct next PC
- redir_tag  out  TAG_W  tag of the redirecting branch

## Operation
- Condition codes: 001 eq, 010 ne, 011 lt, 100 gt, 101 le, 110 ge, 111 unconditional (always taken), 000 not-a-branch (taken=0, never mispredicts). op[3]=0 selects signed compare and op[3]=1 selects unsigned. op[3] is ignored for 001/010/111/000.
- S1 (evaluate): each accepted lane registers taken, mispred = taken ^ pred_taken, correct PC = taken ? target : fallthru, and tag.
- S2 (resolve): res_* is driven from the S1 registers. Among lanes with mispred=1, select the lane with the smallest age = (tag - rob_head) mod 2^TAG_W. If ages are equal, the lowest lane index wins.
- Redirect FSM states:
  - IDLE: if a mispredict is selected in S2, load redir_pc/redir_tag and go to HOLD.
  - HOLD: redir_valid=1 and outputs are held stable. On redir_ready, return to IDLE.
  - While in HOLD, a newly resolved mispredict that is older than the held one replaces it: the FSM stays in HOLD and outputs update the next cycle. A younger mispredict is dropped (res_mispred is still reported).
- Kill: when S2 selects a mispredict, S1 lanes whose tag is younger than the selected tag are invalidated in the same edge.
- in_ready = 1 except in HOLD. While not ready, S1 holds its contents and S2 emits nothing new.
- flush: clears S1, S2 and res_valid, and forces IDLE. It has priority over new issue, mispredict selection and redir_ready in the same cycle.

## Timing
- Reset and flush values: all res_*, redir_valid, redir_pc and redir_tag are 0; FSM is IDLE; in_ready=1.
- Latency: issue at cycle N gives res_valid at N+1. redir_valid rises at N+2 at the earliest.
- Throughput: LANES branches per cycle when not in HOLD.
- redir_ready is sampled only while redir_valid=1. A handshake in cycle M clears redir_valid at M+1.
- Age wrap: a tag equal to rob_head is the oldest. The arithmetic is modulo 2^TAG_W and no sign extension is used.
- Comparisons are exact at any XLEN (for example, signed 0x8000_0000 < 0).

## Structure
- A shared package holds the condition-code constants (BR_NONE, BR_EQ … BR_JMP), the age function, and the per-lane S1 record typedef.
- One sub-module, branch_cond_eval, is purely combinational and instantiated LANES times: it maps op and operands to taken.
- The top-level module contains the pipeline registers, the age selector and the redirect FSM.

## Test plan
- Lane 0 issues op=011 signed with op1=0xFFFF_FFFF, op2=1, pred=0 -> taken=1, mispred=1 at N+1, and redir_pc=target at N+2. The same case with op=1011 gives taken=0 and no redirect.
- Two lanes mispredict in one cycle: tags 5 and 3 with rob_head=2 -> redir_tag=3. With rob_head=4 -> redir_tag=5 (wrap case).
- HOLD with redir_ready=0 for 3 cycles -> in_ready=0 and redir outputs stable. An older mispredict arriving meanwhile replaces redir_tag.
- Mispredict with tag 7 selected while S1 holds tags 9 and 6 -> tag 9 is killed (no res_valid) and tag 6 resolves.
- flush asserted together with a mispredict and redir_ready -> next cycle all outputs are 0 and FSM is IDLE.
- rst_n low mid-HOLD for 1 cycle -> reset values take effect at the next edge, and issue resumes the cycle after rst_n returns high.
